// File: rtl/hwpe_ctrl_context_sequencer_if.sv
// Control-side bundle between the HWPE control slave and the context sequencer.
// slave modport: the sequencer. master modport: the slave/engine glue driving it.
interface hwpe_ctrl_context_sequencer_if #(
  parameter int N_CONTEXT = 2,
  parameter int N_CORES   = 8
);
  localparam int LOG_CORES = $clog2(N_CORES);
  localparam int PW        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;

  logic                 acquire_i;
  logic                 trigger_i;
  logic [LOG_CORES-1:0] src_i;
  logic                 engine_ready_i;
  logic                 engine_done_i;
  logic                 start_o;
  logic                 is_critical_o;
  logic                 full_context_o;
  logic [PW-1:0]        pointer_context_o;
  logic [PW-1:0]        running_context_o;
  logic                 true_done_o;
  logic                 busy_o;
  logic [N_CORES-1:0]   evt_o;

  modport slave (
    input  acquire_i, trigger_i, src_i, engine_ready_i, engine_done_i,
    output start_o, is_critical_o, full_context_o, pointer_context_o,
           running_context_o, true_done_o, busy_o, evt_o
  );

  modport master (
    output acquire_i, trigger_i, src_i, engine_ready_i, engine_done_i,
    input  start_o, is_critical_o, full_context_o, pointer_context_o,
           running_context_o, true_done_o, busy_o, evt_o
  );
endinterface

// File: rtl/hwpe_ctrl_context_sequencer.sv
// Context sequencer: acquire/trigger lock arbitration, ring allocation and
// retirement of job contexts, engine launch and per-core completion events.
// Optional feature: define HWPE_CTRL_LOCK_TIMEOUT_EN to release a lock that is
// held for LOCK_TIMEOUT cycles without an accepted trigger.
module hwpe_ctrl_context_sequencer #(
  parameter int N_CONTEXT    = 2,
  parameter int N_CORES      = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hwpe_ctrl_context_sequencer_if.slave ctrl
);
  localparam int LOG_CORES = $clog2(N_CORES);
  localparam int PW        = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int CW        = $clog2(N_CONTEXT + 1);

  typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [LOG_CORES-1:0] r_lock_owner;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_run;
  logic                 r_running;
  logic                 r_start;
  logic                 r_true_done;
  logic [N_CORES-1:0]   r_evt;
  logic [LOG_CORES-1:0] r_owner [N_CONTEXT];

  logic w_full;
  logic w_acq_grant;
  logic w_trig_acc;
  logic w_dispatch;
  logic w_done_acc;
  logic w_timeout;

  // Ring pointer increment; pointers stay at 0 when there is a single context.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(N_CONTEXT - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign w_full     = (r_cnt == CW'(N_CONTEXT));
  assign w_dispatch = (r_cnt != {CW{1'b0}}) & ~r_running & ~r_true_done & ctrl.engine_ready_i;
  assign w_done_acc = ctrl.engine_done_i & r_running & ~r_true_done;

`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  logic [TW-1:0] r_lock_cnt;

  // Lock hold counter: zero while unlocked, so it starts from 0 on every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_cnt <= {TW{1'b0}};
    end else if (clear_i || (r_state == UNLOCKED)) begin
      r_lock_cnt <= {TW{1'b0}};
    end else begin
      r_lock_cnt <= r_lock_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == LOCKED) && (r_lock_cnt == TW'(LOCK_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Lock FSM next state; trigger is judged against the pre-update lock state,
  // so an acquire in the same cycle as a trigger sees LOCKED and is denied.
  always_comb begin
    w_state_nxt = r_state;
    w_acq_grant = 1'b0;
    w_trig_acc  = 1'b0;
    case (r_state)
      UNLOCKED: begin
        if (ctrl.acquire_i && !w_full) begin
          w_acq_grant = 1'b1;
          w_state_nxt = LOCKED;
        end else begin
          w_state_nxt = UNLOCKED;
        end
      end
      LOCKED: begin
        if (ctrl.trigger_i && (ctrl.src_i == r_lock_owner) && !w_full) begin
          w_trig_acc  = 1'b1;
          w_state_nxt = UNLOCKED;
        end else if (w_timeout) begin
          w_state_nxt = UNLOCKED;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  // Lock state and owner registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= UNLOCKED;
      r_lock_owner <= {LOG_CORES{1'b0}};
    end else if (clear_i) begin
      r_state      <= UNLOCKED;
      r_lock_owner <= {LOG_CORES{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_acq_grant) begin
        r_lock_owner <= ctrl.src_i;
      end
    end
  end

  // Context ring: allocation on trigger, retirement on true_done, occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= {CW{1'b0}};
      r_ptr <= {PW{1'b0}};
      r_run <= {PW{1'b0}};
      for (int i = 0; i < N_CONTEXT; i++) r_owner[i] <= {LOG_CORES{1'b0}};
    end else if (clear_i) begin
      r_cnt <= {CW{1'b0}};
      r_ptr <= {PW{1'b0}};
      r_run <= {PW{1'b0}};
      for (int i = 0; i < N_CONTEXT; i++) r_owner[i] <= {LOG_CORES{1'b0}};
    end else begin
      if (w_trig_acc) begin
        r_owner[r_ptr] <= ctrl.src_i;
        r_ptr          <= ptr_inc(r_ptr);
      end
      if (r_true_done) begin
        r_run <= ptr_inc(r_run);
      end
      case ({w_trig_acc, r_true_done})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Engine launch/completion: registered start, done and one-hot owner event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_running   <= 1'b0;
      r_start     <= 1'b0;
      r_true_done <= 1'b0;
      r_evt       <= {N_CORES{1'b0}};
    end else if (clear_i) begin
      r_running   <= 1'b0;
      r_start     <= 1'b0;
      r_true_done <= 1'b0;
      r_evt       <= {N_CORES{1'b0}};
    end else begin
      r_start     <= w_dispatch;
      r_true_done <= w_done_acc;
      r_evt       <= w_done_acc ? (N_CORES'(1) << r_owner[r_run]) : {N_CORES{1'b0}};
      if (w_dispatch) begin
        r_running <= 1'b1;
      end else if (r_true_done) begin
        r_running <= 1'b0;
      end else begin
        r_running <= r_running;
      end
    end
  end

  assign ctrl.start_o           = r_start;
  assign ctrl.is_critical_o     = (r_state == LOCKED);
  assign ctrl.full_context_o    = w_full;
  assign ctrl.busy_o            = (r_cnt != {CW{1'b0}});
  assign ctrl.pointer_context_o = r_ptr;
  assign ctrl.running_context_o = r_run;
  assign ctrl.true_done_o       = r_true_done;
  assign ctrl.evt_o             = r_evt;
endmodule

// File: tb/tb_hwpe_ctrl_context_sequencer.sv
// Directed bench for hwpe_ctrl_context_sequencer (N_CONTEXT=2, N_CORES=8).
// The lock-timeout steps run only when HWPE_CTRL_LOCK_TIMEOUT_EN is defined.
module tb_hwpe_ctrl_context_sequencer;
  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  hwpe_ctrl_context_sequencer_if #(.N_CONTEXT(2), .N_CORES(8)) ctrl_if ();

  hwpe_ctrl_context_sequencer #(.N_CONTEXT(2), .N_CORES(8), .LOCK_TIMEOUT(16)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .ctrl    (ctrl_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic acquire(input int core);
    ctrl_if.acquire_i = 1'b1;
    ctrl_if.src_i     = 3'(core);
    step();
    ctrl_if.acquire_i = 1'b0;
  endtask

  task automatic trigger(input int core);
    ctrl_if.trigger_i = 1'b1;
    ctrl_if.src_i     = 3'(core);
    step();
    ctrl_if.trigger_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(ctrl_if.start_o), 32'd0);
    chk({tag, "_crit"},  32'(ctrl_if.is_critical_o), 32'd0);
    chk({tag, "_full"},  32'(ctrl_if.full_context_o), 32'd0);
    chk({tag, "_busy"},  32'(ctrl_if.busy_o), 32'd0);
    chk({tag, "_ptr"},   32'(ctrl_if.pointer_context_o), 32'd0);
    chk({tag, "_run"},   32'(ctrl_if.running_context_o), 32'd0);
    chk({tag, "_done"},  32'(ctrl_if.true_done_o), 32'd0);
    chk({tag, "_evt"},   32'(ctrl_if.evt_o), 32'd0);
  endtask

  initial begin
    ctrl_if.acquire_i      = 1'b0;
    ctrl_if.trigger_i      = 1'b0;
    ctrl_if.src_i          = 3'd0;
    ctrl_if.engine_ready_i = 1'b1;
    ctrl_if.engine_done_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // Core 3 acquires, then triggers.
    chk("t1_crit_pre", 32'(ctrl_if.is_critical_o), 32'd0);
    acquire(3);
    chk("t1_crit_locked", 32'(ctrl_if.is_critical_o), 32'd1);
    step();
    chk("t1_crit_hold", 32'(ctrl_if.is_critical_o), 32'd1);
    trigger(3);
    chk("t1_crit_rel", 32'(ctrl_if.is_critical_o), 32'd0);
    chk("t1_busy", 32'(ctrl_if.busy_o), 32'd1);
    chk("t1_ptr", 32'(ctrl_if.pointer_context_o), 32'd1);
    chk("t1_start_early", 32'(ctrl_if.start_o), 32'd0);
    step();
    chk("t1_start", 32'(ctrl_if.start_o), 32'd1);
    step();
    chk("t1_start_width", 32'(ctrl_if.start_o), 32'd0);
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t1_done", 32'(ctrl_if.true_done_o), 32'd1);
    chk("t1_evt", 32'(ctrl_if.evt_o), 32'h08);
    chk("t1_run_during", 32'(ctrl_if.running_context_o), 32'd0);
    step();
    chk("t1_done_width", 32'(ctrl_if.true_done_o), 32'd0);
    chk("t1_evt_width", 32'(ctrl_if.evt_o), 32'h00);
    chk("t1_busy_after", 32'(ctrl_if.busy_o), 32'd0);
    chk("t1_run_after", 32'(ctrl_if.running_context_o), 32'd1);

    // Core 1 locks, core 2 is denied and its trigger ignored, core 1 triggers.
    acquire(1);
    chk("t2_crit_during_acq2", 32'(ctrl_if.is_critical_o), 32'd1);
    acquire(2);
    chk("t2_crit_still", 32'(ctrl_if.is_critical_o), 32'd1);
    trigger(2);
    chk("t2_trig2_ignored_busy", 32'(ctrl_if.busy_o), 32'd0);
    chk("t2_trig2_ignored_crit", 32'(ctrl_if.is_critical_o), 32'd1);
    trigger(1);
    chk("t2_trig1_busy", 32'(ctrl_if.busy_o), 32'd1);
    chk("t2_trig1_ptr_wrap", 32'(ctrl_if.pointer_context_o), 32'd0);
    step();
    chk("t2_start", 32'(ctrl_if.start_o), 32'd1);
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t2_evt", 32'(ctrl_if.evt_o), 32'h02);
    chk("t2_run_during", 32'(ctrl_if.running_context_o), 32'd1);
    step();
    chk("t2_run_after", 32'(ctrl_if.running_context_o), 32'd0);

    // Fill both contexts while the engine is held off.
    ctrl_if.engine_ready_i = 1'b0;
    acquire(4);
    trigger(4);
    acquire(5);
    trigger(5);
    chk("t3_full", 32'(ctrl_if.full_context_o), 32'd1);
    chk("t3_start_held", 32'(ctrl_if.start_o), 32'd0);
    acquire(6);
    chk("t3_acq_denied", 32'(ctrl_if.is_critical_o), 32'd0);
    ctrl_if.engine_ready_i = 1'b1;
    step();
    chk("t3_start0", 32'(ctrl_if.start_o), 32'd1);
    chk("t3_run0", 32'(ctrl_if.running_context_o), 32'd0);
    step();
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t3_evt0", 32'(ctrl_if.evt_o), 32'h10);
    step();
    chk("t3_not_full", 32'(ctrl_if.full_context_o), 32'd0);
    chk("t3_gap_no_start", 32'(ctrl_if.start_o), 32'd0);
    step();
    chk("t3_start1", 32'(ctrl_if.start_o), 32'd1);
    chk("t3_run1", 32'(ctrl_if.running_context_o), 32'd1);
    step();
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t3_evt1", 32'(ctrl_if.evt_o), 32'h20);
    step();
    chk("t3_ptr_wrap", 32'(ctrl_if.pointer_context_o), 32'd0);
    chk("t3_run_wrap", 32'(ctrl_if.running_context_o), 32'd0);
    chk("t3_idle", 32'(ctrl_if.busy_o), 32'd0);

    // Trigger in the same cycle as true_done.
    acquire(0);
    trigger(0);
    step();
    chk("t4_start", 32'(ctrl_if.start_o), 32'd1);
    acquire(7);
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t4_done", 32'(ctrl_if.true_done_o), 32'd1);
    chk("t4_evt", 32'(ctrl_if.evt_o), 32'h01);
    trigger(7);
    chk("t4_busy", 32'(ctrl_if.busy_o), 32'd1);
    chk("t4_not_full", 32'(ctrl_if.full_context_o), 32'd0);
    chk("t4_ptr", 32'(ctrl_if.pointer_context_o), 32'd0);
    chk("t4_run", 32'(ctrl_if.running_context_o), 32'd1);
    chk("t4_unlocked", 32'(ctrl_if.is_critical_o), 32'd0);
    step();
    chk("t4_start2", 32'(ctrl_if.start_o), 32'd1);
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t4_evt2", 32'(ctrl_if.evt_o), 32'h80);
    step();
    chk("t4_idle", 32'(ctrl_if.busy_o), 32'd0);

    // Clear while a job is running and the lock is held.
    acquire(2);
    trigger(2);
    step();
    chk("t5_start", 32'(ctrl_if.start_o), 32'd1);
    acquire(5);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk_all_zero("t5_clear");
    ctrl_if.engine_done_i = 1'b1;
    step();
    ctrl_if.engine_done_i = 1'b0;
    chk("t5_done_ignored", 32'(ctrl_if.true_done_o), 32'd0);
    chk("t5_evt_ignored", 32'(ctrl_if.evt_o), 32'h00);
    step();
    chk_all_zero("t5_after");

`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
    // Lock released after 16 cycles without trigger; late trigger ignored.
    acquire(6);
    for (int i = 1; i < 16; i++) begin
      chk("t6_crit_held", 32'(ctrl_if.is_critical_o), 32'd1);
      step();
    end
    chk("t6_crit_last", 32'(ctrl_if.is_critical_o), 32'd1);
    step();
    chk("t6_crit_timeout", 32'(ctrl_if.is_critical_o), 32'd0);
    trigger(6);
    chk("t6_late_trig_busy", 32'(ctrl_if.busy_o), 32'd0);
    chk("t6_late_trig_ptr", 32'(ctrl_if.pointer_context_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
